// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter with memory-mapped PEND/MASK/EDGE/CAUSE/EOI registers.
// Requests cross a synchronizer; one source is armed, taken in user mode, then held until EOI.
module irq_arbiter #(
  parameter int          NSRC        = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h40000030
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            pc31,
  input  logic [31:0]     mem_addr,
  input  logic [31:0]     mem_wdata,
  input  logic            mem_wr,
  input  logic            mem_rd,
  output logic [31:0]     mem_rdata,
  output logic            irq,
  output logic [2:0]      irq_id
);

  localparam logic [31:0] A_PEND  = BASE_ADDR;
  localparam logic [31:0] A_MASK  = BASE_ADDR + 32'h4;
  localparam logic [31:0] A_EDGE  = BASE_ADDR + 32'h8;
  localparam logic [31:0] A_CAUSE = BASE_ADDR + 32'hC;
  localparam logic [31:0] A_EOI   = BASE_ADDR + 32'h10;

  typedef enum logic [1:0] {IDLE, ARM, SERVICE} state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] sync_d [SYNC_STAGES];
  logic [NSRC-1:0] s_dly_q, s_dly_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic [2:0]      irq_id_q, irq_id_d;

  logic [NSRC-1:0] s, rise, avail, edge_chg;
  logic            wr_pend, wr_mask, wr_edge, wr_eoi;
  logic            any_avail, cur_avail, take;
  logic [2:0]      win_id;
  logic            unused_wdata;

  assign unused_wdata = ^mem_wdata;

  always_comb begin
    sync_d[0] = src;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    s       = sync_q[SYNC_STAGES-1];
    s_dly_d = s;
    rise    = s & ~s_dly_q;

    wr_pend = mem_wr && (mem_addr == A_PEND);
    wr_mask = mem_wr && (mem_addr == A_MASK);
    wr_edge = mem_wr && (mem_addr == A_EDGE);
    wr_eoi  = mem_wr && (mem_addr == A_EOI);

    mask_d   = wr_mask ? mem_wdata[NSRC-1:0] : mask_q;
    edge_d   = wr_edge ? mem_wdata[NSRC-1:0] : edge_q;
    edge_chg = wr_edge ? (mem_wdata[NSRC-1:0] ^ edge_q) : '0;

    avail     = pend_q & mask_q;
    any_avail = |avail;
    win_id    = 3'd0;
    for (int i = NSRC-1; i >= 0; i--) begin
      if (avail[i]) win_id = i[2:0];
    end
    cur_avail = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (irq_id_q == i[2:0]) cur_avail = avail[i];
    end

    state_d  = state_q;
    irq_id_d = irq_id_q;
    take     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_avail) begin
          state_d  = ARM;
          irq_id_d = win_id;
        end
      end
      ARM: begin
        if (!cur_avail) begin
          state_d = IDLE;
        end else if (!pc31) begin
          state_d = SERVICE;
          take    = 1'b1;
        end
      end
      SERVICE: begin
        if (wr_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new edge beats both W1C and the take-clear; a mode switch beats everything.
    for (int i = 0; i < NSRC; i++) begin
      if (edge_chg[i]) begin
        pend_d[i] = 1'b0;
      end else if (edge_q[i]) begin
        if (rise[i])                              pend_d[i] = 1'b1;
        else if (wr_pend && mem_wdata[i])         pend_d[i] = 1'b0;
        else if (take && (irq_id_q == i[2:0]))    pend_d[i] = 1'b0;
        else                                      pend_d[i] = pend_q[i];
      end else begin
        pend_d[i] = s[i];
      end
    end
  end

  always_comb begin
    mem_rdata = 32'd0;
    if (mem_rd) begin
      case (mem_addr)
        A_PEND:  mem_rdata[NSRC-1:0] = pend_q;
        A_MASK:  mem_rdata[NSRC-1:0] = mask_q;
        A_EDGE:  mem_rdata[NSRC-1:0] = edge_q;
        A_CAUSE: mem_rdata = {(state_q != IDLE), 28'd0, irq_id_q};
        default: mem_rdata = 32'd0;
      endcase
    end
  end

  assign irq    = (state_q == ARM);
  assign irq_id = irq_id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_dly_q  <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      irq_id_q <= 3'd0;
      state_q  <= IDLE;
    end else begin
      sync_q   <= sync_d;
      s_dly_q  <= s_dly_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      irq_id_q <= irq_id_d;
      state_q  <= state_d;
    end
  end

endmodule
